// File: rtl/branch_predict_unit_if.sv
// Bus between the pipeline and the branch predict unit.
//
// Purpose: carries the fetch-stage lookup, the ID/EX resolve/update signals
// and the unit's status, statistics and debug outputs.
//
// Handshake: ex_valid qualifies every ex_* field and every flag input.
// stall_en is the back-pressure signal. While stall_en is high, the
// pipeline keeps ex_* stable. The branch is consumed (resolved) in the
// first cycle where ex_valid is high and stall_en is low. If ex_valid
// drops while the unit is waiting, the held branch is withdrawn (flushed)
// and leaves no trace in the table or the statistics.
//
// Signals (direction seen from the unit, i.e. the slave modport):
//   if_pc          in   fetch PC for lookup
//   pred_taken     out  prediction for if_pc
//   ex_valid       in   ID/EX slot holds a live instruction
//   ex_opcode      in   4'hC = B, 4'hD = BR
//   ex_ccc         in   condition code
//   ex_pc          in   PC of the ID/EX instruction
//   ex_pred_taken  in   prediction made at fetch
//   flags          in   {Z,V,N}
//   flags_valid    in   flags are up to date
//   br_hazard      in   BR target register not yet available
//   take_branch    out  resolved taken
//   stall_en       out  hold IF/ID, insert bubble
//   mispredict     out  flush and redirect
//   br_count       out  branches resolved (saturating)
//   mp_count       out  mispredicts (saturating)
//   dbg_state      out  resolution FSM state, 0 = IDLE, 1 = WAIT
interface branch_predict_unit_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  if_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [2:0]       ex_ccc;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic [2:0]       flags;
  logic             flags_valid;
  logic             br_hazard;
  logic             take_branch;
  logic             stall_en;
  logic             mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;
  logic             dbg_state;

  modport master (
    output if_pc, ex_valid, ex_opcode, ex_ccc, ex_pc, ex_pred_taken,
           flags, flags_valid, br_hazard,
    input  pred_taken, take_branch, stall_en, mispredict,
           br_count, mp_count, dbg_state
  );

  modport slave (
    input  if_pc, ex_valid, ex_opcode, ex_ccc, ex_pc, ex_pred_taken,
           flags, flags_valid, br_hazard,
    output pred_taken, take_branch, stall_en, mispredict,
           br_count, mp_count, dbg_state
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predict unit.
//
// Purpose: predicts branches at fetch using a PC-indexed table of
// saturating counters. It resolves B/BR in ID/EX and stalls only while
// the flags or the BR register are not ready. It flags mispredicts so the
// pipeline can flush, and it keeps branch and mispredict statistics.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    branch_predict_unit_if.slave (lookup, resolve, status, debug)
module branch_predict_unit #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [3:0] OP_B  = 4'hC;
  localparam logic [3:0] OP_BR = 4'hD;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] table_q [ENTRIES];
  logic [CNT_W-1:0] br_count_q, mp_count_q;

  logic             flag_z, flag_v, flag_n;
  logic             is_br, cond_met, resolve;
  logic [IDX_W-1:0] lookup_idx, update_idx;

  // Instructions are 2-byte aligned, so bit 0 of the PC never selects an entry.
  assign lookup_idx = bus.if_pc[IDX_W:1];
  assign update_idx = bus.ex_pc[IDX_W:1];

  // The remaining PC bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[PC_W-1:IDX_W+1], bus.if_pc[0],
                            bus.ex_pc[PC_W-1:IDX_W+1], bus.ex_pc[0]};

  assign {flag_z, flag_v, flag_n} = bus.flags;

  always_comb begin
    cond_met = 1'b0;
    case (bus.ex_ccc)
      3'b000: cond_met = ~flag_z;
      3'b001: cond_met = flag_z;
      3'b010: cond_met = ~flag_z & ~flag_n;
      3'b011: cond_met = flag_n;
      3'b100: cond_met = flag_z | (~flag_z & ~flag_n);
      3'b101: cond_met = flag_n | flag_z;
      3'b110: cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  assign is_br = bus.ex_valid & ((bus.ex_opcode == OP_B) | (bus.ex_opcode == OP_BR));

  // An unconditional branch ignores the flags. Only BR depends on the target register.
  assign bus.stall_en = is_br &
                        ((~bus.flags_valid & (bus.ex_ccc != 3'b111)) |
                         ((bus.ex_opcode == OP_BR) & bus.br_hazard));

  assign resolve         = is_br & ~bus.stall_en;
  assign bus.take_branch = resolve & cond_met;
  assign bus.mispredict  = resolve & (bus.take_branch ^ bus.ex_pred_taken);

  // The lookup reads the registered table, so a same-cycle update to the
  // same entry is seen only from the next cycle on.
  assign bus.pred_taken = table_q[lookup_idx][CTR_W-1];

  assign bus.br_count  = br_count_q;
  assign bus.mp_count  = mp_count_q;
  assign bus.dbg_state = state_q;

  // Resolution tracking: WAIT covers the cycles in which a branch is held
  // by a stall. The branch leaves WAIT when it resolves or when it is flushed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.stall_en) state_d = WAIT;
      WAIT:    if (resolve || !bus.ex_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (resolve) begin
      if (bus.take_branch) begin
        if (table_q[update_idx] != {CTR_W{1'b1}})
          table_q[update_idx] <= table_q[update_idx] + 1'b1;
      end else begin
        if (table_q[update_idx] != '0)
          table_q[update_idx] <= table_q[update_idx] - 1'b1;
      end
      if (br_count_q != {CNT_W{1'b1}}) br_count_q <= br_count_q + 1'b1;
      if (bus.mispredict && (mp_count_q != {CNT_W{1'b1}}))
        mp_count_q <= mp_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit. Counters use a narrow statistics width
// so that saturation can be reached in a few dozen cycles.
module tb_branch_predict_unit;

  localparam int PC_W  = 16;
  localparam int IDX_W = 4;
  localparam int CTR_W = 2;
  localparam int CNT_W = 6;
  localparam int CTR_MAX = 2 ** CTR_W - 1;
  localparam int CNT_MAX = 2 ** CNT_W - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model state
  int m_tbl [2 ** IDX_W];
  int m_br, m_mp;
  bit m_wait;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [2:0] ccc, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 2 ** (CTR_W - 1) - 1;
    m_br = 0;
    m_mp = 0;
    m_wait = 1'b0;
  endtask

  task automatic set_ex(input bit v, input logic [3:0] op, input logic [2:0] ccc,
                        input logic [15:0] pc, input bit pred);
    bus.ex_valid = v; bus.ex_opcode = op; bus.ex_ccc = ccc;
    bus.ex_pc = pc; bus.ex_pred_taken = pred;
  endtask

  task automatic set_flags(input logic [2:0] f, input bit fv, input bit hz);
    bus.flags = f; bus.flags_valid = fv; bus.br_hazard = hz;
  endtask

  // One clock cycle: the outputs are checked mid-cycle against the model,
  // and the model then takes the clock edge.
  task automatic step(input string tag);
    bit is_br, stall, res, tk, mp, pr;
    int idx;
    #2;
    is_br = bus.ex_valid && (bus.ex_opcode == 4'hC || bus.ex_opcode == 4'hD);
    stall = is_br && ((!bus.flags_valid && bus.ex_ccc != 3'b111) ||
                      (bus.ex_opcode == 4'hD && bus.br_hazard));
    res = is_br && !stall;
    tk  = res && cond_ok(bus.ex_ccc, bus.flags);
    mp  = res && (tk != bus.ex_pred_taken);
    pr  = m_tbl[int'(bus.if_pc[IDX_W:1])] >= 2 ** (CTR_W - 1);
    check({tag, ".pred_taken"},  32'(bus.pred_taken),  32'(pr));
    check({tag, ".stall_en"},    32'(bus.stall_en),    32'(stall));
    check({tag, ".take_branch"}, 32'(bus.take_branch), 32'(tk));
    check({tag, ".mispredict"},  32'(bus.mispredict),  32'(mp));
    check({tag, ".br_count"},    32'(bus.br_count),    32'(m_br));
    check({tag, ".mp_count"},    32'(bus.mp_count),    32'(m_mp));
    check({tag, ".dbg_state"},   32'(bus.dbg_state),   32'(m_wait));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (res) begin
        idx = int'(bus.ex_pc[IDX_W:1]);
        m_tbl[idx] = tk ? ((m_tbl[idx] < CTR_MAX) ? m_tbl[idx] + 1 : CTR_MAX)
                        : ((m_tbl[idx] > 0) ? m_tbl[idx] - 1 : 0);
        m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
        if (mp) m_mp = (m_mp < CNT_MAX) ? m_mp + 1 : CNT_MAX;
      end
      if (m_wait) m_wait = !(res || !bus.ex_valid);
      else        m_wait = stall;
    end
    @(negedge clk);
  endtask

  task automatic scan_table(input string tag);
    set_ex(1'b0, 4'h0, 3'd0, 16'h0, 1'b0);
    for (int i = 0; i < 2 ** IDX_W; i++) begin
      bus.if_pc = 16'(i << 1);
      step(tag);
    end
  endtask

  initial begin
    bus.if_pc = '0;
    set_ex(1'b0, 4'h0, 3'd0, 16'h0, 1'b0);
    set_flags(3'b000, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    step("reset_hold");
    rst_n = 1'b1;

    // 1. After reset every entry predicts not-taken. Then a taken B mispredicts.
    scan_table("t1_scan");
    bus.if_pc = 16'h0004;
    set_ex(1'b1, 4'hC, 3'b001, 16'h0004, 1'b0);
    set_flags(3'b100, 1'b1, 1'b0);
    step("t1_resolve");
    check("t1_mp_count_is_1", 32'(bus.mp_count), 32'd1);
    set_ex(1'b0, 4'h0, 3'd0, 16'h0, 1'b0);
    step("t1_entry2");
    check("t1_entry2_pred", 32'(bus.pred_taken), 32'd1);

    // 2. Flags not ready for 3 cycles on B ne.
    set_ex(1'b1, 4'hC, 3'b000, 16'h0008, 1'b0);
    set_flags(3'b100, 1'b0, 1'b0);
    repeat (3) step("t2_stall");
    set_flags(3'b000, 1'b1, 1'b0);
    step("t2_resolve");
    check("t2_br_count_is_2", 32'(bus.br_count), 32'd2);

    // 3. BR always with a 2-cycle register hazard. flags_valid does not matter.
    set_ex(1'b1, 4'hD, 3'b111, 16'h000A, 1'b1);
    set_flags(3'b000, 1'b0, 1'b1);
    repeat (2) step("t3_stall");
    set_flags(3'b000, 1'b0, 1'b0);
    step("t3_resolve");

    // 4. Saturation of one entry in both directions.
    bus.if_pc = 16'h0010;
    set_ex(1'b1, 4'hC, 3'b111, 16'h0010, 1'b1);
    set_flags(3'b000, 1'b1, 1'b0);
    repeat (5) step("t4_taken");
    set_ex(1'b1, 4'hC, 3'b001, 16'h0010, 1'b1);
    repeat (4) step("t4_not_taken");
    set_ex(1'b0, 4'h0, 3'd0, 16'h0, 1'b0);
    step("t4_final");

    // 5a. Flush while waiting.
    set_ex(1'b1, 4'hC, 3'b000, 16'h0012, 1'b0);
    set_flags(3'b000, 1'b0, 1'b0);
    step("t5_enter_wait");
    check("t5_in_wait", 32'(bus.dbg_state), 32'd1);
    set_ex(1'b0, 4'hC, 3'b000, 16'h0012, 1'b0);
    step("t5_flush");
    check("t5_back_idle", 32'(bus.dbg_state), 32'd0);

    // 5b. Reset in the middle of a wait, after entry 7 has been driven to taken.
    bus.if_pc = 16'h000E;
    set_ex(1'b1, 4'hC, 3'b111, 16'h000E, 1'b0);
    set_flags(3'b000, 1'b1, 1'b0);
    repeat (2) step("t5_train");
    set_ex(1'b1, 4'hD, 3'b111, 16'h000E, 1'b0);
    set_flags(3'b000, 1'b1, 1'b1);
    step("t5_wait2");
    rst_n = 1'b0;
    step("t5_reset_in_wait");
    rst_n = 1'b1;
    set_flags(3'b000, 1'b1, 1'b0);
    scan_table("t5_scan");

    // 6. Same-cycle lookup and update of index 3, followed by mp_count saturation.
    bus.if_pc = 16'h0006;
    set_ex(1'b1, 4'hC, 3'b111, 16'h0006, 1'b0);
    step("t6_same_cycle");
    set_ex(1'b0, 4'h0, 3'd0, 16'h0, 1'b0);
    step("t6_next_cycle");
    set_ex(1'b1, 4'hC, 3'b001, 16'h0006, 1'b0);
    set_flags(3'b100, 1'b1, 1'b0);
    repeat (CNT_MAX + 4) step("t6_mp_sat");
    check("t6_mp_count_max", 32'(bus.mp_count), 32'(CNT_MAX));
    check("t6_br_count_max", 32'(bus.br_count), 32'(CNT_MAX));

    // Randomized traffic. A waiting branch is held stable, as the pipeline
    // is required to do.
    rst_n = 1'b0;
    step("rand_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.if_pc = 16'($urandom) & 16'hFFFE;
      if (m_wait) begin
        if ($urandom_range(0, 9) == 0) bus.ex_valid = 1'b0;
      end else begin
        case ($urandom_range(0, 3))
          0: bus.ex_opcode = 4'hC;
          1: bus.ex_opcode = 4'hD;
          default: bus.ex_opcode = 4'($urandom);
        endcase
        bus.ex_valid = ($urandom_range(0, 4) != 0);
        bus.ex_ccc = 3'($urandom);
        bus.ex_pc = 16'($urandom) & 16'hFFFE;
        bus.ex_pred_taken = 1'($urandom);
      end
      set_flags(3'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
